// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: opcode encodings and default instruction address width.
package mips32_pkg;

    localparam int AW_DEFAULT = 10;

    typedef enum logic [5:0] {
        OP_ADD   = 6'b000000,
        OP_SUB   = 6'b000001,
        OP_AND   = 6'b000010,
        OP_OR    = 6'b000011,
        OP_SLT   = 6'b000100,
        OP_MUL   = 6'b000101,
        OP_LW    = 6'b001000,
        OP_SW    = 6'b001001,
        OP_ADDI  = 6'b001010,
        OP_SUBI  = 6'b001011,
        OP_SLTI  = 6'b001100,
        OP_BNEQZ = 6'b001101,
        OP_BEQZ  = 6'b001110,
        OP_HLT   = 6'b111111
    } opcode_t;

    function automatic logic is_hlt(input logic [31:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus: instruction memory request/response, branch redirect and IF/ID output.
interface mips32_fetch_queue_if
    import mips32_pkg::*;
#(
    parameter int AW = AW_DEFAULT
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [31:0]   out_ir;
    logic [31:0]   out_npc;
    logic          out_ready;
    logic          halt_seen;

    modport master (
        output imem_req, imem_addr, out_valid, out_ir, out_npc, halt_seen,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_ir, out_npc, halt_seen,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/mips32_fifo.sv
// First-word-fall-through FIFO with synchronous flush; push at full is accepted when a pop coincides.
module mips32_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: o_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch queue: credit-limited prefetch into an {addr, instruction} FIFO with redirect and halt.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter int            AW       = AW_DEFAULT,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    mips32_fetch_queue_if.master   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = AW + 32;

    logic [AW-1:0] r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic          r_halted;
    logic          r_started;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_live;
    logic [AW-1:0] w_rsp_addr;
    logic          w_dropping;
    logic          w_credit_ok;
    logic          w_req;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_valid;
    logic [FW-1:0] w_fifo_data;

    assign w_dropping  = (r_drop_cnt != '0);
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_count}) < (CW+1)'(DEPTH);
    assign w_req       = r_started && !r_halted && !bus.redirect && w_credit_ok;
    assign w_grant     = w_req && bus.imem_gnt;

    // Live requests since the last redirect are consecutive and end at r_pc-1,
    // so the next kept response belongs to r_pc minus their count.
    assign w_live     = r_outstanding - r_drop_cnt;
    assign w_rsp_addr = r_pc - AW'(w_live);

    assign w_push = bus.imem_rvalid && !bus.redirect && !w_dropping && !r_halted;
    assign w_pop  = w_fifo_valid && bus.out_ready && !bus.redirect;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_halted      <= 1'b0;
            r_started     <= 1'b0;
        end else begin
            r_started     <= 1'b1;
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(bus.imem_rvalid);
            if (bus.redirect) begin
                r_pc       <= bus.redirect_pc;
                r_halted   <= 1'b0;
                r_drop_cnt <= r_outstanding - CW'(bus.imem_rvalid);
            end else begin
                if (w_grant) r_pc <= r_pc + AW'(1);
                if (w_push && is_hlt(bus.imem_rdata)) r_halted <= 1'b1;
                if (w_dropping && bus.imem_rvalid) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    mips32_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk1),
        .rst_n   (rst_n),
        .i_flush (bus.redirect),
        .i_push  (w_push),
        .i_data  ({w_rsp_addr, bus.imem_rdata}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_ir    = w_fifo_valid ? w_fifo_data[31:0] : 32'h0;
    assign bus.out_npc   = w_fifo_valid ? (32'(w_fifo_data[FW-1:32]) + 32'd1) : 32'h0;
    assign bus.halt_seen = r_halted;
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: queue-based reference model plus in-order memory with programmable latency.
module tb_mips32_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    mips32_fetch_queue_if #(.AW(AW)) bus ();

    mips32_fetch_queue #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (10'd0)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct { logic [AW-1:0] addr; int due; bit stale; } infl_t;
    typedef struct { logic [AW-1:0] addr; logic [31:0] word; } ent_t;

    infl_t       inflight[$];
    ent_t        buffer[$];
    logic [31:0] mem [1024];
    logic [AW-1:0] m_pc;
    bit          m_halted;
    bit          m_started;
    int          cyc, lat, gnt_pct, rdy_pct, n_gnt;
    int          checks, failures;
    logic [31:0] obs_npc[$];
    logic [31:0] obs_ir[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    // One clock: drive at negedge, check after settling, advance model, return at next negedge.
    task automatic cycle(input bit redir, input logic [AW-1:0] rpc);
        bit          gnt, rdy, rv, exp_req, hlt;
        logic [31:0] rd;
        infl_t       e;
        ent_t        n;
        gnt = (int'($urandom_range(99)) < gnt_pct);
        rdy = (int'($urandom_range(99)) < rdy_pct);
        rv  = (inflight.size() > 0) && (inflight[0].due <= cyc);
        rd  = rv ? mem[inflight[0].addr] : $urandom;
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.out_ready   = rdy;
        #1;
        exp_req = m_started && !m_halted && !redir && (inflight.size() + buffer.size() < DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        chk("out_valid", 32'(bus.out_valid), 32'(buffer.size() != 0));
        chk("out_ir", bus.out_ir, (buffer.size() != 0) ? buffer[0].word : 32'h0);
        chk("out_npc", bus.out_npc, (buffer.size() != 0) ? (32'(buffer[0].addr) + 32'd1) : 32'h0);
        chk("halt_seen", 32'(bus.halt_seen), 32'(m_halted));
        chk("occupancy", 32'(dut.w_count), 32'(buffer.size()));
        if (bus.imem_req && gnt) n_gnt++;
        if (bus.out_valid && rdy && !redir) begin
            obs_npc.push_back(bus.out_npc);
            obs_ir.push_back(bus.out_ir);
        end

        if ((buffer.size() != 0) && rdy && !redir) buffer.delete(0);
        hlt = 1'b0;
        if (rv) begin
            e = inflight.pop_front();
            if (!redir && !e.stale && !m_halted) begin
                n.addr = e.addr;
                n.word = rd;
                buffer.push_back(n);
                hlt = (rd[31:26] == 6'h3F);
            end
        end
        if (redir) begin
            buffer.delete();
            for (int i = 0; i < inflight.size(); i++) begin
                e = inflight[i];
                e.stale = 1'b1;
                inflight[i] = e;
            end
            m_pc     = rpc;
            m_halted = 1'b0;
        end else begin
            if (exp_req && gnt) begin
                e.addr  = m_pc;
                e.due   = cyc + lat;
                e.stale = 1'b0;
                inflight.push_back(e);
                m_pc = m_pc + 10'd1;
            end
            if (hlt) m_halted = 1'b1;
        end
        m_started = 1'b1;
        @(posedge clk1);
        cyc++;
        @(negedge clk1);
    endtask

    task automatic do_reset(input bit check);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_out_ir", bus.out_ir, 32'h0);
            chk("rst_out_npc", bus.out_npc, 32'h0);
            chk("rst_halt_seen", 32'(bus.halt_seen), 32'h0);
        end
        inflight.delete();
        buffer.delete();
        m_pc      = '0;
        m_halted  = 1'b0;
        m_started = 1'b0;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        bit ok;
        checks = 0; failures = 0; cyc = 0; n_gnt = 0;
        lat = 1; gnt_pct = 100; rdy_pct = 100;
        for (int i = 0; i < 1024; i++) mem[i] = rand_word();

        do_reset(1'b1);

        // Back-to-back streaming from reset with a 1-cycle memory
        obs_npc.delete(); obs_ir.delete(); n_gnt = 0;
        repeat (12) cycle(1'b0, '0);
        chk("b2b_grants", 32'(n_gnt), 32'd11);
        chk("seq_npc0", (obs_npc.size() > 0) ? obs_npc[0] : 32'hFFFF_FFFF, 32'd1);
        chk("seq_npc1", (obs_npc.size() > 1) ? obs_npc[1] : 32'hFFFF_FFFF, 32'd2);
        chk("seq_npc2", (obs_npc.size() > 2) ? obs_npc[2] : 32'hFFFF_FFFF, 32'd3);
        chk("seq_npc3", (obs_npc.size() > 3) ? obs_npc[3] : 32'hFFFF_FFFF, 32'd4);

        // Back-pressure: credits allow exactly DEPTH grants, then resume without loss
        gnt_pct = 0;
        repeat (6) cycle(1'b0, '0);
        gnt_pct = 100; rdy_pct = 0; n_gnt = 0;
        repeat (12) cycle(1'b0, '0);
        chk("stall_grants", 32'(n_gnt), 32'd4);
        chk("stall_req_low", 32'(bus.imem_req), 32'h0);
        obs_npc.delete(); obs_ir.delete(); rdy_pct = 100;
        repeat (16) cycle(1'b0, '0);
        ok = (obs_npc.size() >= 8);
        for (int i = 0; i < obs_npc.size(); i++) if (obs_npc[i] !== 32'(12 + i)) ok = 1'b0;
        chk("resume_seq", 32'(ok), 32'd1);

        // Redirect with three stale responses in flight
        lat = 3;
        guard = 0;
        while (inflight.size() != 3 && guard < 20) begin
            cycle(1'b0, '0);
            guard++;
        end
        chk("wait_outstanding3", 32'(guard < 20), 32'd1);
        obs_npc.delete(); obs_ir.delete();
        cycle(1'b1, 10'h040);
        chk("redir_valid_low", 32'(bus.out_valid), 32'h0);
        repeat (14) cycle(1'b0, '0);
        chk("redir_first_ir", (obs_ir.size() > 0) ? obs_ir[0] : 32'hFFFF_FFFF, mem[10'h040]);
        chk("redir_first_npc", (obs_npc.size() > 0) ? obs_npc[0] : 32'hFFFF_FFFF, 32'h41);

        // Randomized traffic at each latency with occasional redirects
        for (int ph = 0; ph < 3; ph++) begin
            lat = ph + 1; gnt_pct = 70; rdy_pct = 60;
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(99) < 4) cycle(1'b1, AW'($urandom_range(1023)));
                else                        cycle(1'b0, '0);
            end
        end

        // HLT at word 5 stops fetching; buffered words through the HLT still drain
        mem[5] = 32'hFC00_0000;
        lat = 2; gnt_pct = 100; rdy_pct = 100;
        obs_npc.delete(); obs_ir.delete();
        cycle(1'b1, 10'h000);
        repeat (30) cycle(1'b0, '0);
        chk("hlt_seen", 32'(bus.halt_seen), 32'd1);
        chk("hlt_req_low", 32'(bus.imem_req), 32'h0);
        chk("hlt_count", 32'(obs_npc.size()), 32'd6);
        chk("hlt_last_npc", (obs_npc.size() > 0) ? obs_npc[obs_npc.size()-1] : 32'hFFFF_FFFF, 32'd6);
        chk("hlt_last_ir", (obs_ir.size() > 0) ? obs_ir[obs_ir.size()-1] : 32'h0, 32'hFC00_0000);

        // PC wrap at the top of the address space
        mem[5] = rand_word();
        lat = 1;
        obs_npc.delete(); obs_ir.delete();
        cycle(1'b1, 10'h3FE);
        repeat (10) cycle(1'b0, '0);
        chk("wrap_npc_3fe", (obs_npc.size() > 0) ? obs_npc[0] : 32'hFFFF_FFFF, 32'h3FF);
        chk("wrap_npc_3ff", (obs_npc.size() > 1) ? obs_npc[1] : 32'hFFFF_FFFF, 32'h400);
        chk("wrap_npc_000", (obs_npc.size() > 2) ? obs_npc[2] : 32'hFFFF_FFFF, 32'h1);

        // Asynchronous reset with two words buffered and one request outstanding
        lat = 3; rdy_pct = 0; gnt_pct = 0;
        cycle(1'b1, 10'h100);
        guard = 0;
        while (!(buffer.size() == 2 && inflight.size() == 1) && guard < 30) begin
            gnt_pct = (inflight.size() + buffer.size() < 3) ? 100 : 0;
            cycle(1'b0, '0);
            guard++;
        end
        chk("wait_2buf_1out", 32'(guard < 30), 32'd1);
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        do_reset(1'b1);
        lat = 1; gnt_pct = 100; rdy_pct = 100;
        obs_npc.delete(); obs_ir.delete();
        repeat (8) cycle(1'b0, '0);
        chk("refetch_npc0", (obs_npc.size() > 0) ? obs_npc[0] : 32'hFFFF_FFFF, 32'd1);
        chk("refetch_ir0", (obs_ir.size() > 0) ? obs_ir[0] : 32'hFFFF_FFFF, mem[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 Parameter DEPTH, 4, number of instruction buffer entries (power of two, 2..16).
REQ-002 Parameter AW, 10, word-address width into the 1024-word instruction memory.
REQ-003 Parameter RESET_PC, 0, first word address fetched after reset.
REQ-004 clk1  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  read request to instruction memory.
REQ-007 imem_addr  out  AW  word address of the request.
REQ-008 imem_gnt  in  1  memory accepts the request this cycle.
REQ-009 imem_rvalid  in  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 redirect  in  1  taken-branch redirect from EX/MEM; one-cycle pulse.
REQ-012 redirect_pc  in  AW  branch target word address.
REQ-013 out_valid  out  1  instruction available to the IF/ID register.
REQ-014 out_ir  out  32  instruction word, equivalent to IF_ID_IR.
REQ-015 out_npc  out  32  instruction address + 1, zero-extended, equivalent to IF_ID_NPC.
REQ-016 out_ready  in  1  decode consumes the head entry when out_valid and out_ready are both high.
REQ-017 halt_seen  out  1  an HLT (opcode 6'b111111) has been enqueued and fetching is stopped.

Function
REQ-018 The block SHALL keep a fetch PC (AW bits) that advances by 1 on each granted request and wraps from 2^AW-1 to 0.
REQ-019 imem_req SHALL be high iff not halted, redirect is low, and outstanding + occupancy < DEPTH (credit rule).
REQ-020 imem_addr SHALL equal the fetch PC whenever imem_req is high.
REQ-021 A granted request SHALL increment outstanding; an accepted or dropped response SHALL decrement it; both in one cycle SHALL leave it unchanged.
REQ-022 Each accepted response SHALL be enqueued with its own address, held in a DEPTH-deep in-order address tag FIFO, so that out_npc = address + 1.
REQ-023 The FIFO SHALL be first-word-fall-through with 1-cycle minimum latency from rvalid to out_valid; simultaneous enqueue and dequeue SHALL be legal at any occupancy.
REQ-024 Overflow SHALL NOT occur; the credit rule guarantees this, and verification SHALL assert it.
REQ-025 On redirect, the block SHALL empty the FIFO, set the fetch PC to redirect_pc, clear halt_seen, and set drop_cnt to outstanding minus any response arriving in that cycle.
REQ-026 While drop_cnt > 0, each rvalid SHALL be discarded and SHALL decrement drop_cnt; the first request to redirect_pc SHALL issue the cycle after redirect.
REQ-027 A dequeue coinciding with redirect SHALL be ignored; out_valid SHALL be low in the cycle after redirect.
REQ-028 When an enqueued word has opcode [31:26] = 6'b111111, halt_seen SHALL go high the next cycle, imem_req SHALL stay low, and later non-dropped responses SHALL be discarded.
REQ-029 After halt_seen, entries already buffered, including the HLT, SHALL still drain normally.

Reset
REQ-030 Reset SHALL asynchronously set: fetch PC = RESET_PC, FIFO empty, outstanding = 0, drop_cnt = 0, halt_seen = 0, out_valid = 0, imem_req = 0, out_ir = 0, out_npc = 0.
REQ-031 Requests SHALL start no earlier than the second rising edge after rst_n deasserts.
REQ-032 Responses arriving during or after reset for pre-reset requests are the memory's responsibility, and the block SHALL NOT track them.

Structure
REQ-033 Opcode constants (HLT = 6'b111111) and AW default SHALL reside in shared package mips32_pkg with the other pipeline opcodes.
REQ-034 The buffer SHALL be one sub-module, mips32_fifo (parameterised width/depth, FWFT, flush input), instanced for {addr, instruction}.

Verification
REQ-035 Reset, 1-cycle memory, out_ready=1 -> addresses 0,1,2,3... issued back-to-back; out_npc sequence 1,2,3,4.
REQ-036 out_ready=0, DEPTH=4 -> exactly 4 grants then imem_req low; out_ready high again -> requests resume, no loss/duplication.
REQ-037 3-cycle latency, 3 outstanding, redirect to 0x040 -> 3 stale responses dropped; first out_ir is Mem[0x040], out_npc = 0x41.
REQ-038 Word 0x005 = 32'hFC000000 -> halt_seen set, no request beyond outstanding, HLT delivered with out_npc = 6, nothing after it.
REQ-039 PC = 0x3FF -> next request address 0x000, out_npc for 0x3FF = 0x400.
REQ-040 rst_n asserted with 2 entries buffered and 1 outstanding -> all outputs at reset values immediately; refetch from RESET_PC.
